// File: rtl/seq_step_ctrl_if.sv
// Control and status bundle for the step-sequencer timing controller.
// start/stop are single-cycle requests sampled on every rising clk; pause and loop are levels;
// status outputs are registered and valid one cycle after the edge that caused them.
interface seq_step_ctrl_if #(
  parameter int PRE_W   = 16,
  parameter int DIGIT_W = 4
);
  logic               start;
  logic               stop;
  logic               pause;
  logic               loop;
  logic [PRE_W-1:0]   div;
  logic [DIGIT_W-1:0] len_u;
  logic [DIGIT_W-1:0] len_t;
  logic               busy;
  logic               step_ce;
  logic [DIGIT_W-1:0] q_u;
  logic [DIGIT_W-1:0] q_t;
  logic               wrap;
  logic               done;

  modport master (
    output start, stop, pause, loop, div, len_u, len_t,
    input  busy, step_ce, q_u, q_t, wrap, done
  );

  modport slave (
    input  start, stop, pause, loop, div, len_u, len_t,
    output busy, step_ce, q_u, q_t, wrap, done
  );
endinterface

// File: rtl/seq_step_ctrl.sv
// Step-sequencer timing controller: prescaled step ticks drive a two-digit BCD step counter
// sequenced through IDLE/RUN/PAUSED/DONE.
module seq_step_ctrl #(
  parameter int PRE_W   = 16,
  parameter int DIGIT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  seq_step_ctrl_if.slave   bus,
  output logic [1:0]       state_dbg
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_RUN    = 2'd1;
  localparam logic [1:0] S_PAUSED = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  localparam logic [DIGIT_W-1:0] NINE = DIGIT_W'(9);

  logic [1:0]         state;
  logic [PRE_W-1:0]   presc;
  logic [PRE_W-1:0]   div_l;
  logic [DIGIT_W-1:0] q_u, q_t;
  logic [DIGIT_W-1:0] last_u, last_t;
  logic               busy, step_ce, wrap, done;

  logic [PRE_W-1:0]   div_eff;
  logic [DIGIT_W-1:0] lu_c, lt_c;
  logic [DIGIT_W-1:0] last_u_n, last_t_n;
  logic               tick;
  logic               at_last;

  // The last step index (LEN-1) is latched as BCD so the end test is a plain digit compare;
  // a length of 00 means 100 steps, so the last step is 99.
  always_comb begin
    div_eff  = (bus.div == '0) ? PRE_W'(1) : bus.div;
    lu_c     = (bus.len_u > NINE) ? NINE : bus.len_u;
    lt_c     = (bus.len_t > NINE) ? NINE : bus.len_t;
    last_u_n = NINE;
    last_t_n = NINE;
    if (lu_c != '0) begin
      last_u_n = lu_c - DIGIT_W'(1);
      last_t_n = lt_c;
    end else if (lt_c != '0) begin
      last_u_n = NINE;
      last_t_n = lt_c - DIGIT_W'(1);
    end
  end

  assign tick    = (presc == div_l - PRE_W'(1));
  assign at_last = (q_u == last_u) && (q_t == last_t);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      presc   <= '0;
      div_l   <= PRE_W'(1);
      q_u     <= '0;
      q_t     <= '0;
      last_u  <= NINE;
      last_t  <= NINE;
      busy    <= 1'b0;
      step_ce <= 1'b0;
      wrap    <= 1'b0;
      done    <= 1'b0;
    end else begin
      step_ce <= 1'b0;
      wrap    <= 1'b0;
      done    <= 1'b0;
      if (bus.stop) begin
        state <= S_IDLE;
        presc <= '0;
        q_u   <= '0;
        q_t   <= '0;
        busy  <= 1'b0;
      end else if (bus.start) begin
        state   <= S_RUN;
        presc   <= '0;
        q_u     <= '0;
        q_t     <= '0;
        div_l   <= div_eff;
        last_u  <= last_u_n;
        last_t  <= last_t_n;
        busy    <= 1'b1;
        step_ce <= 1'b1;
      end else if (state == S_RUN || state == S_PAUSED) begin
        if (bus.pause) begin
          // Freeze everything, including a tick that would have landed this cycle.
          state <= S_PAUSED;
        end else begin
          // Leaving PAUSED counts in the same cycle, so the remaining period is exact.
          state <= S_RUN;
          if (tick) begin
            presc <= '0;
            if (at_last) begin
              if (bus.loop) begin
                q_u     <= '0;
                q_t     <= '0;
                div_l   <= div_eff;
                step_ce <= 1'b1;
                wrap    <= 1'b1;
              end else begin
                state <= S_DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end
            end else begin
              step_ce <= 1'b1;
              if (q_u == NINE) begin
                q_u <= '0;
                q_t <= (q_t == NINE) ? '0 : q_t + DIGIT_W'(1);
              end else begin
                q_u <= q_u + DIGIT_W'(1);
              end
            end
          end else begin
            presc <= presc + PRE_W'(1);
          end
        end
      end
    end
  end

  assign bus.busy    = busy;
  assign bus.step_ce = step_ce;
  assign bus.q_u     = q_u;
  assign bus.q_t     = q_t;
  assign bus.wrap    = wrap;
  assign bus.done    = done;
  assign state_dbg   = state;

endmodule

// File: tb/tb_seq_step_ctrl.sv
// Directed bench for seq_step_ctrl: hand-computed step timing, BCD carry, pause, loop/done,
// restart, stop priority and asynchronous reset.
module tb_seq_step_ctrl;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_RUN    = 2'd1;
  localparam logic [1:0] S_PAUSED = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  logic       clk;
  logic       rst_n;
  logic [1:0] state_dbg;
  int         n_chk;
  int         n_bad;
  logic [7:0] exp_q[$];

  seq_step_ctrl_if #(.PRE_W(16), .DIGIT_W(4)) bus ();

  seq_step_ctrl #(.PRE_W(16), .DIGIT_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
  endtask

  task automatic do_stop();
    bus.stop = 1'b1;
    cyc();
    bus.stop = 1'b0;
  endtask

  task automatic set_cfg(input logic [15:0] d, input logic [3:0] lt, input logic [3:0] lu,
                         input logic lp);
    bus.div   = d;
    bus.len_t = lt;
    bus.len_u = lu;
    bus.loop  = lp;
  endtask

  function automatic logic [7:0] bcd(input int k);
    return {4'(k / 10), 4'(k % 10)};
  endfunction

  // scoreboard
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] qv();
    return {bus.q_t, bus.q_u};
  endfunction

  initial begin
    n_chk = 0;
    n_bad = 0;
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    bus.pause = 1'b0;
    set_cfg(16'd1, 4'd0, 4'd1, 1'b0);
    repeat (3) cyc();
    chk("rst_busy", bus.busy, 0);
    chk("rst_q", qv(), 8'h00);
    chk("rst_ce", bus.step_ce, 0);
    chk("rst_state", state_dbg, S_IDLE);
    rst_n = 1'b1;
    cyc();
    chk("idle_ce", bus.step_ce, 0);

    // DIV=3, LEN=12, loop: steps every 3 clocks, wrap 36 clocks after first step
    set_cfg(16'd3, 4'd1, 4'd2, 1'b1);
    do_start();
    chk("a_q0", qv(), 8'h00);
    chk("a_ce0", bus.step_ce, 1);
    chk("a_busy", bus.busy, 1);
    for (int k = 1; k <= 11; k++) exp_q.push_back(bcd(k));
    exp_q.push_back(8'h00);
    set_cfg(16'd7, 4'd0, 4'd2, 1'b1);  // changes between latch points must not matter
    set_cfg(16'd3, 4'd1, 4'd2, 1'b1);
    for (int c = 1; c <= 36; c++) begin
      if (c == 2) set_cfg(16'd7, 4'd0, 4'd2, 1'b1);
      if (c == 34) set_cfg(16'd3, 4'd1, 4'd2, 1'b1);
      cyc();
      chk("a_ce", bus.step_ce, (c % 3 == 0));
      chk("a_wrap", bus.wrap, (c == 36));
      if (c % 3 == 0) begin
        if (exp_q.size() > 0) chk("a_q", qv(), exp_q.pop_front());
        else chk("a_q_underflow", 1, 0);
      end
    end
    chk("a_q_left", exp_q.size(), 0);
    do_stop();
    chk("a_stop_state", state_dbg, S_IDLE);
    chk("a_stop_q", qv(), 8'h00);
    chk("a_stop_ce", bus.step_ce, 0);

    // DIV=1, LEN=3, no loop: 00,01,02 then DONE
    set_cfg(16'd1, 4'd0, 4'd3, 1'b0);
    do_start();
    chk("b_q0", qv(), 8'h00);
    cyc();
    chk("b_q1", qv(), 8'h01);
    chk("b_ce1", bus.step_ce, 1);
    cyc();
    chk("b_q2", qv(), 8'h02);
    cyc();
    chk("b_done", bus.done, 1);
    chk("b_ce3", bus.step_ce, 0);
    chk("b_q3", qv(), 8'h02);
    chk("b_busy", bus.busy, 0);
    chk("b_state", state_dbg, S_DONE);
    bus.pause = 1'b1;
    cyc();
    bus.pause = 1'b0;
    chk("b_done_pulse", bus.done, 0);
    chk("b_ce4", bus.step_ce, 0);
    chk("b_hold_state", state_dbg, S_DONE);
    chk("b_hold_q", qv(), 8'h02);

    // DIV=4, pause after two prescaler counts for five clocks
    set_cfg(16'd4, 4'd0, 4'd9, 1'b1);
    do_start();
    cyc();
    cyc();
    bus.pause = 1'b1;
    for (int c = 0; c < 5; c++) begin
      cyc();
      chk("c_p_ce", bus.step_ce, 0);
      chk("c_p_q", qv(), 8'h00);
      chk("c_p_busy", bus.busy, 1);
      chk("c_p_state", state_dbg, S_PAUSED);
    end
    bus.pause = 1'b0;
    cyc();
    chk("c_r1_ce", bus.step_ce, 0);
    chk("c_r1_state", state_dbg, S_RUN);
    cyc();
    chk("c_r2_ce", bus.step_ce, 1);
    chk("c_r2_q", qv(), 8'h01);

    // advance to step 05, then restart
    repeat (16) cyc();
    chk("d_q5", qv(), 8'h05);
    chk("d_ce5", bus.step_ce, 1);
    do_start();
    chk("d_rs_q", qv(), 8'h00);
    chk("d_rs_ce", bus.step_ce, 1);
    for (int c = 1; c <= 4; c++) begin
      cyc();
      chk("d_rs_tick", bus.step_ce, (c == 4));
    end
    chk("d_rs_q1", qv(), 8'h01);

    // STOP and START together: STOP wins
    bus.start = 1'b1;
    bus.stop  = 1'b1;
    cyc();
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    chk("e_state", state_dbg, S_IDLE);
    chk("e_q", qv(), 8'h00);
    chk("e_ce", bus.step_ce, 0);
    chk("e_busy", bus.busy, 0);
    cyc();
    chk("e_ce2", bus.step_ce, 0);

    // DIV=0 acts as 1, LEN_U=F clamps to 9
    set_cfg(16'd0, 4'd0, 4'hF, 1'b0);
    do_start();
    for (int c = 1; c <= 8; c++) begin
      cyc();
      chk("f_ce", bus.step_ce, 1);
      chk("f_q", qv(), bcd(c));
    end
    cyc();
    chk("f_done", bus.done, 1);
    chk("f_q_hold", qv(), 8'h08);
    chk("f_ce_end", bus.step_ce, 0);

    // LEN=00 means 100 steps; wrap on the 100th advance
    set_cfg(16'd1, 4'd0, 4'd0, 1'b1);
    do_start();
    for (int c = 1; c <= 100; c++) begin
      cyc();
      chk("g_q", qv(), (c == 100) ? 8'h00 : bcd(c));
      chk("g_wrap", bus.wrap, (c == 100));
    end
    chk("g_ce", bus.step_ce, 1);

    // asynchronous reset between edges while running
    set_cfg(16'd2, 4'd0, 4'd9, 1'b1);
    do_start();
    cyc();
    cyc();
    chk("h_pre_busy", bus.busy, 1);
    rst_n = 1'b0;
    #1;
    chk("h_busy", bus.busy, 0);
    chk("h_q", qv(), 8'h00);
    chk("h_ce", bus.step_ce, 0);
    chk("h_state", state_dbg, S_IDLE);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      cyc();
      chk("h_after_ce", bus.step_ce, 0);
      chk("h_after_state", state_dbg, S_IDLE);
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
